// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: in-order imem requests, a response buffer of
// {addr, word} pairs, a valid/ready decode interface, and redirect flushing.
module instr_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_nxt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_baddr [DEPTH];
  logic [XLEN-1:0] r_bdata [DEPTH];
  logic [XLEN-1:0] r_qaddr [DEPTH];
  ptr_t            r_bwr, r_brd, r_qwr, r_qrd;
  cnt_t            r_bcnt, r_outst, r_disc;
  logic            r_post_rst;

  logic            w_pop, w_allow, w_fire, w_rsp, w_keep, w_drop;
  logic [CW:0]     w_occ;

  assign if_valid  = (r_bcnt != '0);
  assign if_instr  = r_bdata[r_brd];
  assign if_pc     = r_baddr[r_brd];
  assign imem_addr = pc;

  assign w_pop   = if_valid & if_ready;
  // Outstanding includes responses still to be discarded, so occupancy stays
  // bounded across a redirect.
  assign w_occ   = {1'b0, r_bcnt} + {1'b0, r_outst};
  assign w_allow = (w_occ < DEPTH_C) | ((w_occ == DEPTH_C) & w_pop);
  assign imem_req = reset_n & ~redirect_valid & w_allow;
  assign w_fire  = imem_req & imem_gnt;
  assign w_rsp   = imem_rvalid & (r_outst != '0);
  assign w_keep  = w_rsp & (r_disc == '0) & ~redirect_valid;
  assign w_drop  = w_rsp & (r_disc != '0) & ~redirect_valid;

  always_comb begin
    pc_nxt = pc;
    if (redirect_valid) pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    else if (w_fire)    pc_nxt = pc + XLEN'(4);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bwr      <= '0;
      r_brd      <= '0;
      r_qwr      <= '0;
      r_qrd      <= '0;
      r_bcnt     <= '0;
      r_outst    <= '0;
      r_disc     <= '0;
      r_post_rst <= 1'b1;
    end else begin
      if (w_fire) r_post_rst <= 1'b0;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old stream.
        r_bwr   <= '0;
        r_brd   <= '0;
        r_qwr   <= '0;
        r_qrd   <= '0;
        r_bcnt  <= '0;
        r_outst <= r_outst - cnt_t'(w_rsp);
        r_disc  <= r_outst - cnt_t'(w_rsp);
      end else begin
        if (w_keep) begin
          r_bwr <= r_bwr + ptr_t'(1);
          r_qrd <= r_qrd + ptr_t'(1);
        end
        if (w_pop)  r_brd  <= r_brd + ptr_t'(1);
        if (w_fire) r_qwr  <= r_qwr + ptr_t'(1);
        if (w_drop) r_disc <= r_disc - cnt_t'(1);
        r_bcnt  <= r_bcnt + cnt_t'(w_keep) - cnt_t'(w_pop);
        r_outst <= r_outst + cnt_t'(w_fire) - cnt_t'(w_rsp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !redirect_valid && w_keep) begin
      r_baddr[r_bwr] <= r_qaddr[r_qrd];
      r_bdata[r_bwr] <= imem_rdata;
    end
    if (w_fire) r_qaddr[r_qwr] <= pc;
  end

  // Responses to pre-reset requests may still trickle in before the first new grant.
  assert property (@(posedge clk) disable iff (!reset_n || r_post_rst)
                   !(imem_rvalid && (r_outst == '0)))
    else $error("imem_rvalid with no outstanding request");

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: epoch-tagged memory model plus a buffer queue
// predict every cycle's outputs; directed scenarios then a random phase.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] pc_nxt;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [XLEN-1:0] imem_rdata = '0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pc_nxt(pc_nxt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int unsigned due;
  } req_t;

  req_t        pend[$];
  logic [31:0] buf_q[$];
  int          epoch = 0;
  int unsigned cyc = 0;
  int unsigned lat_lo = 1, lat_hi = 1;
  int          n_cmp = 0, n_err = 0;
  int          dut_fires = 0;
  logic [31:0] last_nxt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle, entered and left at a negedge.
  task automatic step(input logic rd, input logic [31:0] tgt, input logic gnt, input logic rdy);
    bit          rv, pop, exp_req;
    int          occ;
    logic [31:0] exp_nxt;
    req_t        r;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    redirect_valid = rd;
    redirect_pc    = tgt;
    imem_gnt       = gnt;
    if_ready       = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem(pend[0].addr) : $urandom;
    #1;
    pop     = (buf_q.size() > 0) && rdy;
    occ     = buf_q.size() + pend.size();
    exp_req = !rd && ((occ < DEPTH) || (occ == DEPTH && pop));
    exp_nxt = rd ? {tgt[31:2], 2'b00} : (exp_req && gnt) ? pc + 32'd4 : pc;
    last_nxt = pc_nxt;
    if (imem_req && gnt) dut_fires++;
    check("if_valid", {31'b0, if_valid}, {31'b0, buf_q.size() > 0});
    if (buf_q.size() > 0) begin
      check("if_pc", if_pc, buf_q[0]);
      check("if_instr", if_instr, mem(buf_q[0]));
    end
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check("imem_addr", imem_addr, pc);
    check("pc_nxt", pc_nxt, exp_nxt);
    if (rv) r = pend.pop_front();
    if (pop) void'(buf_q.pop_front());
    if (rd) begin
      buf_q.delete();
      epoch++;
    end else if (rv && r.ep == epoch) begin
      buf_q.push_back(r.addr);
    end
    if (exp_req && gnt)
      pend.push_back('{pc, epoch, cyc + $urandom_range(lat_hi, lat_lo)});
    @(posedge clk);
    @(negedge clk);
    pc = exp_nxt;
    cyc++;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (buf_q.size() > 0) begin
        seen = 1;
        break;
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    if (seen) check(tag, if_pc, exp_pc);
    else      check({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int f0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Decode stalled from reset: only DEPTH fetches may go out.
    f0 = dut_fires;
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("stall_fires", 32'(dut_fires - f0), 32'd2);
    check("stall_hold_pc", last_nxt, 32'h8);

    // Drain and stream at one instruction per cycle.
    for (int unsigned i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Long latency, redirect with requests in flight.
    lat_lo = 3; lat_hi = 3;
    for (int unsigned i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    wait_valid("redir_200", 32'h200);

    // Redirect in the same cycle as a response, with one more outstanding.
    lat_lo = 2; lat_hi = 2;
    for (int unsigned i = 0; i < 20; i++) begin
      if (pend.size() == 2 && pend[0].due <= cyc) break;
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    check("rv_redir_setup", pend.size(), 32'd2);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    wait_valid("redir_300", 32'h300);

    // Low target bits ignored; PC wraps past the top of memory.
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'h203, 1'b1, 1'b1);
    check("redir_align", last_nxt, 32'h200);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 10; i++) begin
      if (pend.size() == 0) break;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("pc_wrap", last_nxt, 32'h0);
    for (int unsigned i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Random traffic.
    lat_lo = 1; lat_hi = 3;
    for (int unsigned i = 0; i < 400; i++)
      step(($urandom_range(15, 0) == 0), $urandom, $urandom_range(1, 0) == 1,
           $urandom_range(3, 0) != 0);

    // Asynchronous reset mid-stream, then a stale response.
    for (int unsigned i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_req", {31'b0, imem_req}, 32'h0);
    check("async_rst_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    pend.delete();
    buf_q.delete();
    pc             = 32'h0;
    reset_n        = 1'b1;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    if_ready       = 1'b1;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    cyc += 2;
    #1;
    check("stale_rsp_valid", {31'b0, if_valid}, 32'h0);
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end fetch engine. It reads the architectural PC register and returns that register's next value (pc_nxt). It issues in-order read requests to instruction memory and buffers the returned words with their addresses. Decode receives them over a valid/ready handshake. Branch/jump redirects flush buffered and in-flight fetches and retarget the PC.

Parameters:
DEPTH, 2, instruction buffer entries; also the maximum number of outstanding imem requests (power of 2, ≥2).
XLEN, 32, address/data width.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
pc  in  XLEN  current PC from the PC register.
pc_nxt  out  XLEN  next PC to the PC register (combinational).
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  XLEN  redirect target.
imem_req  out  1  fetch request valid.
imem_addr  out  XLEN  fetch address, always equal to pc.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  response valid (in order, ≥1 cycle after grant).
imem_rdata  in  XLEN  response word.
if_valid  out  1  instruction available to decode.
if_ready  in  1  decode accepts.
if_instr  out  XLEN  instruction word.
if_pc  out  XLEN  address of if_instr.

Behaviour:
- Reset (async assert, sync release): buffer empty; outstanding count=0; discard count=0; imem_req=0; if_valid=0. if_instr and if_pc are don't-care while if_valid=0.
- Occupancy: occ = buffered entries + outstanding requests. A new request is allowed when occ < DEPTH, or when occ == DEPTH and a decode pop (if_valid && if_ready) happens in the same cycle.
- imem_req is asserted when reset_n is high, redirect_valid=0, and a new request is allowed. A request fires when imem_req && imem_gnt. On fire, pc_nxt = pc + 4 (mod 2^XLEN, wraps 0xFFFFFFFC→0) and the issued pc is pushed onto an internal address queue.
- No fire and no redirect: pc_nxt = pc. Hold the PC.
- Redirect has priority over everything: pc_nxt = {redirect_pc[XLEN-1:2], 2'b00}, with the low bits ignored. imem_req=0 in that cycle. The instruction buffer is cleared, and if_valid=0 from the next cycle. A pop in the redirect cycle is still honoured if if_ready=1.
- Discard: on redirect, discard count ← outstanding − (imem_rvalid ? 1 : 0), and the address queue drops the same entries. Every subsequent response while discard>0 decrements discard and is dropped. Issuing resumes the cycle after redirect. New-epoch responses are accepted only once discard reaches 0. Ordering guarantees this.
- Response with discard==0: pop the address queue and push {addr, rdata} into the buffer. Decrement outstanding. A response and a pop in the same cycle are both performed.
- Output: if_valid = buffer non-empty. if_instr and if_pc come from the head entry and stay stable while if_valid && !if_ready.
- Latency: grant at cycle N and rvalid at cycle N+k give if_valid at N+k+1 (registered buffer). Throughput is 1 instruction/cycle with k=1 and DEPTH ≥ 2.
- Counters never overflow: outstanding ≤ DEPTH and buffer ≤ DEPTH.
- imem_rvalid with no outstanding request is a protocol error. Assert it in simulation and ignore it in RTL.
- Reset asserted mid-operation clears all state immediately. Responses arriving after reset release with no outstanding request are ignored.

Test Plan:
- Reset pc=0x00000000, imem always grants, 1-cycle latency, if_ready=1 → pc_nxt sequence 0x4, 0x8, 0xC…; if_pc 0x0, 0x4, 0x8 on consecutive cycles from cycle 3; if_instr matches memory.
- if_ready=0 for 10 cycles, DEPTH=2 → exactly 2 requests issued, then imem_req=0 and pc_nxt=pc. Releasing if_ready drains if_pc 0x0, 0x4 in order, then fetching resumes at 0x8.
- Two requests outstanding (0x10, 0x14) at latency 3, redirect_pc=0x200 → both responses dropped; next if_pc=0x200, if_instr=mem[0x200].
- Redirect in the same cycle as imem_rvalid for 0x10, with 0x14 outstanding → discard count=1; if_pc never shows 0x10/0x14.
- redirect_pc=0x203 → pc_nxt=0x200. pc=0xFFFFFFFC fired → pc_nxt=0x00000000.
- reset_n pulsed low asynchronously mid-stream → imem_req and if_valid drop within the same cycle; a stale rvalid after release produces no if_valid.
